core_lsu: RTL

CORE_LSU -- requirements
Module: core_lsu

---
 rtl/core_lsu_pkg.sv | 56 +++++
 rtl/core_lsu_if.sv | 45 ++++
 rtl/core_lsu_lane_align.sv | 67 ++++++
 rtl/core_lsu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared RISC-V load/store definitions: funct3 encodings, LSU state encoding and
// small decode helpers used by core_lsu and lsu_lane_align.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3, input logic is64);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                F3_SD:               ok = is64;
                default:             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                F3_LD, F3_LWU:                       ok = is64;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Low address bits that must be zero for an access of 2^size bytes.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Request/response and memory-side bundle of core_lsu. Signal suffixes are seen
// from the LSU: slave is the LSU view, master is the core/memory-model view.
interface core_lsu_if #(
    parameter int XLEN = 32
) ();
    localparam int NB = XLEN / 8;

    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [2:0]      req_funct3_i;
    logic [XLEN-1:0] req_base_i;
    logic [XLEN-1:0] req_offset_i;
    logic [XLEN-1:0] req_wdata_i;
    logic [4:0]      req_rd_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic [4:0]      rsp_rd_o;
    logic            rsp_err_o;

    logic            mem_req_o;
    logic            mem_gnt_i;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_we_o;
    logic [NB-1:0]   mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_base_i, req_offset_i,
               req_wdata_i, req_rd_i, rsp_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_base_i, req_offset_i,
               req_wdata_i, req_rd_i, rsp_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/core_lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension for one memory word.
module lsu_lane_align
    import riscv_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int LW   = $clog2(NB)
) (
    input  logic [2:0]      funct3_i,
    input  logic [LW-1:0]   lane_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [NB-1:0]   be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] shifted;
    logic            sext;
    logic [XLEN-1:0] ext_b;
    logic [XLEN-1:0] ext_h;
    logic [XLEN-1:0] ext_w;

    assign shifted = rdata_i >> {lane_i, 3'b000};
    assign sext    = ~funct3_i[2];
    assign ext_b   = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
    assign ext_h   = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};

    // Word extension only exists when the datapath is wider than a word.
    generate
        if (XLEN > 32) begin : g_wide
            assign ext_w = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
        end else begin : g_narrow
            assign ext_w = shifted;
        end
    endgenerate

    always_comb begin
        be_o    = '1;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (funct3_i[1:0])
            2'd0: begin
                be_o    = NB'(1) << lane_i;
                wdata_o = {NB{wdata_i[7:0]}};
                rdata_o = ext_b;
            end
            2'd1: begin
                be_o    = NB'(3) << lane_i;
                wdata_o = {(NB/2){wdata_i[15:0]}};
                rdata_o = ext_h;
            end
            2'd2: begin
                be_o    = NB'(15) << lane_i;
                wdata_o = {(NB/4){wdata_i[31:0]}};
                rdata_o = ext_w;
            end
            default: begin
                be_o    = '1;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Single-outstanding RISC-V load/store unit. Define LSU_MISALIGN_TRAP_EN to turn
// misaligned accesses into errors; otherwise they are silently forced aligned.
module core_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic       clk_i,
    input logic       rst_i,
    core_lsu_if.slave bus
);

    localparam int   NB   = XLEN / 8;
    localparam int   LW   = $clog2(NB);
    localparam logic IS64 = (XLEN == 64);

    lsu_state_e      state_q,  state_d;
    logic            we_q,     we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q,   addr_d;
    logic [XLEN-1:0] wdata_q,  wdata_d;
    logic [4:0]      rd_q,     rd_d;
    logic [XLEN-1:0] rdata_q,  rdata_d;
    logic            err_q,    err_d;

    logic [XLEN-1:0] ea;
    logic [2:0]      amask;
    logic            legal;
    logic            reject;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rdata_ext;

    assign ea    = bus.req_base_i + bus.req_offset_i;
    assign amask = size_mask(bus.req_funct3_i[1:0]);
    assign legal = f3_legal(bus.req_we_i, bus.req_funct3_i, IS64);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(ea[2:0] & amask);
    assign reject     = ~legal | misaligned;
`else
    assign reject     = ~legal;
`endif

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3_i (funct3_q),
        .lane_i   (addr_q[LW-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus.mem_rdata_i),
        .be_o     (be),
        .wdata_o  (wdata_rep),
        .rdata_o  (rdata_ext)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    we_d     = bus.req_we_i;
                    funct3_d = bus.req_funct3_i;
                    wdata_d  = bus.req_wdata_i;
                    rdata_d  = '0;
                    err_d    = reject;
                    rd_d     = (!reject && !bus.req_we_i) ? bus.req_rd_i : 5'd0;
                    // With trapping enabled, misaligned EAs never reach REQ, so the mask is a no-op.
                    addr_d   = {ea[XLEN-1:3], ea[2:0] & ~amask};
                    state_d  = reject ? RESP : REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) begin
                    state_d = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rdata_d = rdata_ext;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE) & ~rst_i;
    assign bus.mem_req_o   = (state_q == REQ);
    assign bus.mem_addr_o  = {addr_q[XLEN-1:LW], {LW{1'b0}}};
    assign bus.mem_we_o    = we_q;
    assign bus.mem_be_o    = be;
    assign bus.mem_wdata_o = wdata_rep;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_rd_o    = rd_q;
    assign bus.rsp_err_o   = err_q;

endmodule
